// File: rtl/l2_ifill_responder_if.sv
// -----------------------------------------------------------------------------
// l2_ifill_responder_if
// Bundles the L1-I request/response handshake and the backing-memory beat bus
// of the L2 instruction-fill responder.
//   read_L1_L2 / tag_L1_L2 / index_L1_L2 : L1 refill request (held until ready)
//   flush                                : invalidate all L2 lines
//   ready_L2_L1 / read_data_L2_L1        : one-cycle 512-bit line response
//   mem_read / mem_addr                  : backing-memory line request {tag,index}
//   mem_valid / mem_rdata                : returned beats, lowest beat first
// slave  : the responder's view
// master : the view of the L1 + memory side driving the responder
// -----------------------------------------------------------------------------
interface l2_ifill_responder_if #(
  parameter int TNUM_2 = 18,
  parameter int INUM_2 = 8,
  parameter int BEAT_W = 128
);
  logic                     read_L1_L2;
  logic [TNUM_2-1:0]        tag_L1_L2;
  logic [INUM_2-1:0]        index_L1_L2;
  logic                     flush;
  logic                     ready_L2_L1;
  logic [511:0]             read_data_L2_L1;
  logic                     mem_read;
  logic [TNUM_2+INUM_2-1:0] mem_addr;
  logic                     mem_valid;
  logic [BEAT_W-1:0]        mem_rdata;

  modport slave (
    input  read_L1_L2, tag_L1_L2, index_L1_L2, flush, mem_valid, mem_rdata,
    output ready_L2_L1, read_data_L2_L1, mem_read, mem_addr
  );

  modport master (
    output read_L1_L2, tag_L1_L2, index_L1_L2, flush, mem_valid, mem_rdata,
    input  ready_L2_L1, read_data_L2_L1, mem_read, mem_addr
  );
endinterface

// File: rtl/l2_ifill_responder.sv
// -----------------------------------------------------------------------------
// l2_ifill_responder
// Direct-mapped L2 that serves L1-I refill requests. A hit answers from the
// line array; a miss fetches the line from backing memory in 512/BEAT_W beats,
// installs it, then answers. Each request is answered exactly once; the L1
// must drop read_L1_L2 before a new request is taken.
// Ports:
//   clk  : clock, rising edge
//   nrst : synchronous reset, active high
//   bus  : l2_ifill_responder_if.slave (L1 handshake + memory beat bus)
//   hit_cnt / miss_cnt : 32-bit saturating lookup counters, present only when
//                        the macro L2_PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
module l2_ifill_responder #(
  parameter int TNUM_2 = 18,
  parameter int INUM_2 = 8,
  parameter int BEAT_W = 128
) (
  input  logic                    clk,
  input  logic                    nrst,
  l2_ifill_responder_if.slave     bus
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
`endif
);

  localparam int LINE_W = 512;
  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int NLINES = 1 << INUM_2;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_FILL, RESP, RELEASE} state_t;

  state_t              state;
  logic [NLINES-1:0]   valid_q;
  logic [TNUM_2-1:0]   tag_mem  [NLINES];
  logic [LINE_W-1:0]   data_mem [NLINES];

  logic [TNUM_2-1:0]   tag_p0;
  logic [INUM_2-1:0]   idx_p0;
  logic                flush_pend;
  logic [CNT_W-1:0]    beat_cnt;
  logic [LINE_W-1:0]   fill_buf;
  logic [LINE_W-1:0]   line_asm;
  logic                lookup_hit;
  logic                fill_last;
  logic                fill_we;

`ifdef L2_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  assign lookup_hit = valid_q[idx_p0] && (tag_mem[idx_p0] == tag_p0);

  // Current beat merged into the partially collected line.
  always_comb begin
    line_asm = fill_buf;
    line_asm[BEAT_W*beat_cnt +: BEAT_W] = bus.mem_rdata;
  end

  // Beats only count while the request is actually outstanding.
  assign fill_last = (state == MEM_FILL) && bus.mem_read && bus.mem_valid &&
                     (beat_cnt == CNT_W'(NBEATS - 1));
  // A reset on the final-beat cycle must not install a partial line.
  assign fill_we   = fill_last && !nrst;

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[idx_p0]  <= tag_p0;
      data_mem[idx_p0] <= line_asm;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state               <= IDLE;
      valid_q             <= '0;
      flush_pend          <= 1'b0;
      beat_cnt            <= '0;
      bus.ready_L2_L1     <= 1'b0;
      bus.read_data_L2_L1 <= '0;
      bus.mem_read        <= 1'b0;
      bus.mem_addr        <= '0;
`ifdef L2_PERF_CNT_EN
      hit_cnt             <= '0;
      miss_cnt            <= '0;
`endif
    end else begin
      // A flush arriving mid-request waits so the in-flight fill lands first.
      if (bus.flush && state != IDLE) flush_pend <= 1'b1;

      case (state)
        // Request acceptance: flush wins over a simultaneous read
        IDLE: begin
          if (bus.flush || flush_pend) begin
            valid_q    <= '0;
            flush_pend <= 1'b0;
          end else if (bus.read_L1_L2) begin
            tag_p0 <= bus.tag_L1_L2;
            idx_p0 <= bus.index_L1_L2;
            state  <= LOOKUP;
          end
        end

        // Tag compare against latched request
        LOOKUP: begin
          if (lookup_hit) begin
            bus.ready_L2_L1     <= 1'b1;
            bus.read_data_L2_L1 <= data_mem[idx_p0];
            state               <= RESP;
`ifdef L2_PERF_CNT_EN
            hit_cnt             <= sat_inc(hit_cnt);
`endif
          end else begin
            bus.mem_read <= 1'b1;
            bus.mem_addr <= {tag_p0, idx_p0};
            beat_cnt     <= '0;
            state        <= MEM_FILL;
`ifdef L2_PERF_CNT_EN
            miss_cnt     <= sat_inc(miss_cnt);
`endif
          end
        end

        // Beat collection; the last beat goes straight to the response register
        MEM_FILL: begin
          if (fill_last) begin
            valid_q[idx_p0]     <= 1'b1;
            bus.mem_read        <= 1'b0;
            bus.ready_L2_L1     <= 1'b1;
            bus.read_data_L2_L1 <= line_asm;
            state               <= RESP;
          end else if (bus.mem_read && bus.mem_valid) begin
            fill_buf <= line_asm;
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end

        // Single-cycle response strobe
        RESP: begin
          bus.ready_L2_L1     <= 1'b0;
          bus.read_data_L2_L1 <= '0;
          state               <= RELEASE;
        end

        // Hold off until the L1 drops its request
        RELEASE: begin
          if (!bus.read_L1_L2) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_ifill_responder.sv
// -----------------------------------------------------------------------------
// tb_l2_ifill_responder
// Directed bench: a table of read transactions (tag, index, hit/miss, beat
// seed, hold/gap/flush options) applied in a loop, plus hand-written sequences
// for reset state and reset in the middle of a fill. The index width is 6 so
// that the reference line address {0x2A5F3, 0x11} is 0xA97CD1.
// -----------------------------------------------------------------------------
module tb_l2_ifill_responder;
  localparam int TNUM = 18;
  localparam int INUM = 6;
  localparam int BW   = 128;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  l2_ifill_responder_if #(.TNUM_2(TNUM), .INUM_2(INUM), .BEAT_W(BW)) bus ();

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  l2_ifill_responder #(.TNUM_2(TNUM), .INUM_2(INUM), .BEAT_W(BW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
`ifdef L2_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [17:0] tag;
    logic [5:0]  idx;
    bit          hit;
    logic [3:0]  seed;
    logic [3:0]  hold;
    bit          gap;
    bit          flush_mid;
    bit          flush_req;
  } vec_t;

  vec_t vecs [11];

  // Beat k of a line built from seed s: every nibble equals s+k.
  function automatic logic [127:0] beat(input logic [3:0] s, input int k);
    logic [3:0] n;
    n = s + 4'(k);
    return {32{n}};
  endfunction

  function automatic logic [511:0] line_of(input logic [3:0] s);
    return {beat(s, 3), beat(s, 2), beat(s, 1), beat(s, 0)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic xact(input vec_t v, input int n);
    bus.tag_L1_L2   = v.tag;
    bus.index_L1_L2 = v.idx;
    bus.read_L1_L2  = 1'b1;
    if (v.flush_req) begin
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk($sformatf("v%0d_flushreq_idle", n), {bus.ready_L2_L1, bus.mem_read}, 2'b00);
    end
    step();
    chk($sformatf("v%0d_accept", n), {bus.ready_L2_L1, bus.mem_read}, 2'b00);
    // Request fields change after acceptance; the latched copy must be used.
    bus.tag_L1_L2   = ~v.tag;
    bus.index_L1_L2 = ~v.idx;
    step();
    if (v.hit) begin
      chk($sformatf("v%0d_hit_ready", n), bus.ready_L2_L1, 1'b1);
      chk($sformatf("v%0d_hit_nomem", n), bus.mem_read, 1'b0);
    end else begin
      chk($sformatf("v%0d_miss_memrd", n), {bus.ready_L2_L1, bus.mem_read}, 2'b01);
      chk($sformatf("v%0d_miss_addr", n), bus.mem_addr, {v.tag, v.idx});
      for (int k = 0; k < 4; k++) begin
        if (v.gap && k == 2) begin
          bus.mem_valid = 1'b0;
          step();
          chk($sformatf("v%0d_gap", n), {bus.ready_L2_L1, bus.mem_read}, 2'b01);
        end
        bus.mem_valid = 1'b1;
        bus.mem_rdata = beat(v.seed, k);
        if (v.flush_mid && k == 1) bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        if (k < 3) begin
          chk($sformatf("v%0d_beat%0d", n, k), {bus.ready_L2_L1, bus.mem_read}, 2'b01);
          chk($sformatf("v%0d_addr%0d", n, k), bus.mem_addr, {v.tag, v.idx});
        end
      end
      bus.mem_valid = 1'b0;
      chk($sformatf("v%0d_fill_ready", n), {bus.ready_L2_L1, bus.mem_read}, 2'b10);
    end
    chk($sformatf("v%0d_data", n), bus.read_data_L2_L1, line_of(v.seed));
    step();
    chk($sformatf("v%0d_strobe_end", n), bus.ready_L2_L1, 1'b0);
    chk($sformatf("v%0d_data_zero", n), bus.read_data_L2_L1, 512'd0);
    for (int h = 0; h < int'(v.hold); h++) begin
      step();
      chk($sformatf("v%0d_hold%0d", n, h), {bus.ready_L2_L1, bus.mem_read}, 2'b00);
    end
    bus.read_L1_L2 = 1'b0;
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            tag        idx    hit   seed  hold  gap   fmid  freq
    vecs[0]  = '{18'h2A5F3, 6'h11, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{18'h2A5F3, 6'h11, 1'b1, 4'h0, 4'd5, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{18'h00001, 6'h11, 1'b0, 4'hA, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{18'h2A5F3, 6'h11, 1'b0, 4'h5, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{18'h2A5F3, 6'h11, 1'b1, 4'h5, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{18'h3FFFF, 6'h3F, 1'b0, 4'hC, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{18'h3FFFF, 6'h3F, 1'b1, 4'hC, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{18'h00000, 6'h00, 1'b0, 4'h3, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{18'h00000, 6'h00, 1'b0, 4'h7, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{18'h00000, 6'h00, 1'b1, 4'h7, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{18'h00000, 6'h00, 1'b0, 4'h2, 4'd0, 1'b0, 1'b0, 1'b1};

    nrst            = 1'b1;
    bus.read_L1_L2  = 1'b0;
    bus.tag_L1_L2   = '0;
    bus.index_L1_L2 = '0;
    bus.flush       = 1'b0;
    bus.mem_valid   = 1'b0;
    bus.mem_rdata   = '0;
    step();
    step();
    chk("rst_ready", bus.ready_L2_L1, 1'b0);
    chk("rst_data", bus.read_data_L2_L1, 512'd0);
    chk("rst_memrd", bus.mem_read, 1'b0);
    chk("rst_addr", bus.mem_addr, 24'd0);
    nrst = 1'b0;
    step();

    // Reference line address of the cold-miss vector.
    bus.tag_L1_L2   = 18'h2A5F3;
    bus.index_L1_L2 = 6'h11;
    bus.read_L1_L2  = 1'b1;
    step();
    step();
    chk("ref_addr", bus.mem_addr, 24'hA97CD1);
    chk("ref_line", line_of(4'h0),
        {{32{4'h3}}, {32{4'h2}}, {32{4'h1}}, {32{4'h0}}});
    // Drop this probe through reset so the table starts from an empty cache.
    nrst = 1'b1;
    bus.read_L1_L2 = 1'b0;
    step();
    nrst = 1'b0;
    step();

    for (int i = 0; i < 11; i++) xact(vecs[i], i);

`ifdef L2_PERF_CNT_EN
    chk("cnt_hit_table", hit_cnt, 32'd4);
    chk("cnt_miss_table", miss_cnt, 32'd7);
`endif

    // Reset after the second beat of a fill.
    bus.tag_L1_L2   = 18'h12345;
    bus.index_L1_L2 = 6'h05;
    bus.read_L1_L2  = 1'b1;
    step();
    step();
    chk("rstfill_memrd", bus.mem_read, 1'b1);
    for (int k = 0; k < 2; k++) begin
      bus.mem_valid = 1'b1;
      bus.mem_rdata = beat(4'hE, k);
      step();
    end
    nrst          = 1'b1;
    bus.mem_rdata = beat(4'hE, 2);
    step();
    chk("rstfill_memrd_drop", bus.mem_read, 1'b0);
    chk("rstfill_addr", bus.mem_addr, 24'd0);
    chk("rstfill_ready", bus.ready_L2_L1, 1'b0);
    nrst           = 1'b0;
    bus.read_L1_L2 = 1'b0;
    bus.mem_rdata  = beat(4'hE, 3);
    step();
    chk("late_beat_ignored", {bus.ready_L2_L1, bus.mem_read}, 2'b00);
    bus.mem_valid = 1'b0;
    step();
`ifdef L2_PERF_CNT_EN
    chk("cnt_hit_rst", hit_cnt, 32'd0);
    chk("cnt_miss_rst", miss_cnt, 32'd0);
`endif
    xact('{18'h12345, 6'h05, 1'b0, 4'h6, 4'd0, 1'b0, 1'b0, 1'b0}, 11);
    xact('{18'h12345, 6'h05, 1'b1, 4'h6, 4'd0, 1'b0, 1'b0, 1'b0}, 12);
    // Earlier contents were invalidated by the reset.
    xact('{18'h3FFFF, 6'h3F, 1'b0, 4'h4, 4'd0, 1'b0, 1'b0, 1'b0}, 13);
`ifdef L2_PERF_CNT_EN
    chk("cnt_hit_end", hit_cnt, 32'd1);
    chk("cnt_miss_end", miss_cnt, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/l2_ifill_responder.md
L2_IFILL_RESPONDER -- requirements
Module: l2_ifill_responder

Interface
REQ-001 Parameters SHALL be: TNUM_2, 18, L2 tag width; INUM_2, 8, L2 index width (2^INUM_2 direct-mapped lines); BEAT_W, 128, memory beat width (512/BEAT_W = 4 beats per line).
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 nrst  input  1  synchronous, active-high reset.
REQ-004 read_L1_L2  input  1  L1-I refill request; held high by L1 until ready_L2_L1 is seen.
REQ-005 tag_L1_L2  input  TNUM_2  request tag.
REQ-006 index_L1_L2  input  INUM_2  request index.
REQ-007 flush  input  1  invalidate all L2 lines.
REQ-008 ready_L2_L1  output  1  one-cycle response strobe.
REQ-009 read_data_L2_L1  output  512  refill line, valid while ready_L2_L1=1.
REQ-010 mem_read  output  1  backing-memory line request.
REQ-011 mem_addr  output  TNUM_2+INUM_2  line address {tag,index}.
REQ-012 mem_valid  input  1  one beat present on mem_rdata.
REQ-013 mem_rdata  input  BEAT_W  beat data, lowest beat first.

Function
REQ-014 Storage SHALL be per-line valid bit, TNUM_2-bit tag and 512-bit data, direct-mapped by index.
REQ-015 FSM states SHALL be IDLE, LOOKUP, MEM_FILL, RESP, RELEASE.
REQ-016 IDLE: read_L1_L2=1 and no flush pending -> latch tag/index, go LOOKUP.
REQ-017 LOOKUP (one cycle): valid && tag match -> RESP with stored line; otherwise -> MEM_FILL.
REQ-018 MEM_FILL: mem_read=1 and mem_addr={latched tag,index} held constant; beat k (k=0..3) SHALL be written to line bits [BEAT_W*k +: BEAT_W]; mem_valid while mem_read=0 SHALL be ignored.
REQ-019 On the cycle of the 4th beat, the assembled line, tag and valid=1 SHALL be written to the indexed entry, replacing any previous occupant; next state RESP; mem_read SHALL drop on the following cycle.
REQ-020 RESP: ready_L2_L1=1 for exactly one cycle with read_data_L2_L1 = line; next state RELEASE.
REQ-021 RELEASE: stay until read_L1_L2=0, then IDLE; a request still held high is never served twice.
REQ-022 Latency: hit = ready_L2_L1 two cycles after the cycle of request acceptance; miss = ready_L2_L1 one cycle after the 4th beat.
REQ-023 read_data_L2_L1 SHALL be 0 whenever ready_L2_L1=0.
REQ-024 flush in IDLE SHALL clear all valid bits in one cycle; flush has priority over a simultaneous read_L1_L2, which SHALL be accepted on the next cycle and miss.
REQ-025 flush outside IDLE SHALL set a pending flag, executed on the first IDLE cycle; the in-flight request completes normally and its fill is written before the flush executes.
REQ-026 Tag/index changes while not in IDLE SHALL be ignored (latched copies used).

Reset
REQ-027 nrst=1 SHALL force IDLE; clear all valid bits and the flush-pending flag; set ready_L2_L1=0, read_data_L2_L1=0, mem_read=0, mem_addr=0 on the next edge.
REQ-028 Reset during MEM_FILL SHALL discard collected beats; no array write occurs; late beats are ignored.

Configuration
REQ-029 Macro L2_PERF_CNT_EN defined: add outputs hit_cnt and miss_cnt (32 bits each), incremented on each LOOKUP hit/miss, saturating at 0xFFFF_FFFF, cleared by reset (flush does not clear them).
REQ-030 L2_PERF_CNT_EN undefined: the counters and their ports SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Cold miss: tag 0x2A5F3, index 0x11, beats 0x0..0,0x1..1,0x2..2,0x3..3 -> mem_addr=0xA97CD1; ready_L2_L1 one cycle after the 4th beat; line = {beat3,beat2,beat1,beat0}.
REQ-032 Re-read of the same tag/index -> no mem_read; ready_L2_L1 two cycles after acceptance with the identical line; hit_cnt=1, miss_cnt=1 (with macro).
REQ-033 Conflict: tag 0x00001, index 0x11 -> miss and refill; a following read of tag 0x2A5F3, index 0x11 -> misses again.
REQ-034 flush pulsed during MEM_FILL -> current response delivered; the next read of the same address misses.
REQ-035 nrst after the 2nd beat -> mem_read=0 next cycle; a subsequent read of that address misses and refetches all 4 beats.
REQ-036 read_L1_L2 held high for 5 cycles after ready_L2_L1 -> exactly one response; the next request is accepted only after read_L1_L2 drops low.
